// File: rtl/regfile_wb_ctrl_if.sv
// regfile_wb_ctrl_if: issue, ALU/LSU write-back and regfile write-port bundle.
// master drives requests (i_*); slave (the controller) drives o_*.
interface regfile_wb_ctrl_if;
    logic        i_iss_valid;
    logic [4:0]  i_iss_rd_addr;
    logic [4:0]  i_iss_rs1_addr;
    logic [4:0]  i_iss_rs2_addr;
    logic        o_iss_stall;

    logic        i_alu_valid;
    logic [4:0]  i_alu_rd_addr;
    logic [31:0] i_alu_data;
    logic        o_alu_ready;

    logic        i_lsu_valid;
    logic [4:0]  i_lsu_rd_addr;
    logic [31:0] i_lsu_data;
    logic        o_lsu_ready;

    logic        o_rd_wren;
    logic [4:0]  o_rd_addr;
    logic [31:0] o_rd_data;

    modport master (
        output i_iss_valid, i_iss_rd_addr, i_iss_rs1_addr, i_iss_rs2_addr,
        output i_alu_valid, i_alu_rd_addr, i_alu_data,
        output i_lsu_valid, i_lsu_rd_addr, i_lsu_data,
        input  o_iss_stall, o_alu_ready, o_lsu_ready,
        input  o_rd_wren, o_rd_addr, o_rd_data
    );

    modport slave (
        input  i_iss_valid, i_iss_rd_addr, i_iss_rs1_addr, i_iss_rs2_addr,
        input  i_alu_valid, i_alu_rd_addr, i_alu_data,
        input  i_lsu_valid, i_lsu_rd_addr, i_lsu_data,
        output o_iss_stall, o_alu_ready, o_lsu_ready,
        output o_rd_wren, o_rd_addr, o_rd_data
    );
endinterface

// File: rtl/regfile_wb_ctrl.sv
// regfile_wb_ctrl: ALU/LSU write-port arbiter with LSU starvation guard,
// registered regfile write port, and optional busy scoreboard
// (REGFILE_WB_SCOREBOARD_EN). Ports: i_clk, i_rst (async, active-high),
// wb (slave modport: issue check, ALU/LSU handshakes, rd write port).
module regfile_wb_ctrl #(
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic             i_clk,
    input  logic             i_rst,
    regfile_wb_ctrl_if.slave wb
);

    typedef enum logic {
        ALU_PRI,
        LSU_PRI
    } arb_state_e;

    localparam logic [3:0] STARVE_LAST = 4'(STARVE_MAX - 1);

    arb_state_e  state_q, state_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic        alu_rdy, lsu_rdy;
    logic        lsu_denied;

    logic        grant;
    logic [4:0]  sel_addr;
    logic [31:0] sel_data;
    logic        wren_q;
    logic [4:0]  addr_q;
    logic [31:0] data_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= ALU_PRI;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = '0;
        alu_rdy    = 1'b0;
        lsu_rdy    = 1'b0;
        unique case (state_q)
            ALU_PRI: begin
                alu_rdy = wb.i_alu_valid;
                lsu_rdy = wb.i_lsu_valid & ~wb.i_alu_valid;
            end
            LSU_PRI: begin
                lsu_rdy = wb.i_lsu_valid;
                alu_rdy = wb.i_alu_valid & ~wb.i_lsu_valid;
            end
        endcase
        lsu_denied = wb.i_lsu_valid & ~lsu_rdy;
        if (lsu_denied)
            wait_cnt_d = wait_cnt_q + 4'd1;
        unique case (state_q)
            ALU_PRI: begin
                if (lsu_denied && wait_cnt_q == STARVE_LAST)
                    state_d = LSU_PRI;
            end
            LSU_PRI: begin
                // Priority is held for exactly one LSU grant, or
                // dropped as soon as the LSU withdraws.
                if (lsu_rdy || !wb.i_lsu_valid)
                    state_d = ALU_PRI;
            end
        endcase
    end

    assign wb.o_alu_ready = alu_rdy;
    assign wb.o_lsu_ready = lsu_rdy;

    // Grants are one-hot, so a simple mux picks the winner.
    assign grant    = alu_rdy | lsu_rdy;
    assign sel_addr = lsu_rdy ? wb.i_lsu_rd_addr : wb.i_alu_rd_addr;
    assign sel_data = lsu_rdy ? wb.i_lsu_data : wb.i_alu_data;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wren_q <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            wren_q <= grant && (sel_addr != 5'd0);
            if (grant && (sel_addr != 5'd0)) begin
                addr_q <= sel_addr;
                data_q <= sel_data;
            end
        end
    end

    assign wb.o_rd_wren = wren_q;
    assign wb.o_rd_addr = addr_q;
    assign wb.o_rd_data = data_q;

`ifdef REGFILE_WB_SCOREBOARD_EN
    logic [31:0] busy_q;
    logic [31:0] busy_set, busy_clr;
    logic        hazard;
    logic        stall;

    // rd is included so a second writer to a busy register waits (WAW).
    assign hazard = busy_q[wb.i_iss_rs1_addr] |
                    busy_q[wb.i_iss_rs2_addr] |
                    busy_q[wb.i_iss_rd_addr];
    assign stall  = wb.i_iss_valid & hazard;

    assign busy_set = (wb.i_iss_valid && !stall &&
                       wb.i_iss_rd_addr != 5'd0) ?
                      (32'd1 << wb.i_iss_rd_addr) : 32'd0;
    assign busy_clr = wren_q ? (32'd1 << addr_q) : 32'd0;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            busy_q <= '0;
        else
            busy_q <= ((busy_q & ~busy_clr) | busy_set) & ~32'd1;
    end

    assign wb.o_iss_stall = stall;
`else
    logic unused_iss;
    assign unused_iss = ^{wb.i_iss_valid, wb.i_iss_rd_addr,
                          wb.i_iss_rs1_addr, wb.i_iss_rs2_addr};
    assign wb.o_iss_stall = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// tb_regfile_wb_ctrl: directed and random checks of regfile_wb_ctrl
// against a starvation-streak / busy-set reference model.
module tb_regfile_wb_ctrl;

    localparam int STARVE_MAX = 3;
`ifdef REGFILE_WB_SCOREBOARD_EN
    localparam bit SB = 1'b1;
`else
    localparam bit SB = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    regfile_wb_ctrl_if bus ();

    regfile_wb_ctrl #(.STARVE_MAX(STARVE_MAX)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .wb    (bus)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: the LSU gets priority once it has been refused for
    // STARVE_MAX consecutive cycles; busy is a plain bit-per-register set.
    int          streak;
    bit [31:0]   m_busy;
    bit          m_wren;
    bit [4:0]    m_addr;
    bit [31:0]   m_data;
    bit          g_alu, g_lsu;
    logic        obs_alu, obs_lsu, obs_stall;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        streak = 0;
        m_busy = '0;
        m_wren = 1'b0;
        m_addr = '0;
        m_data = '0;
    endtask

    task automatic idle();
        bus.i_iss_valid    = 1'b0;
        bus.i_iss_rd_addr  = '0;
        bus.i_iss_rs1_addr = '0;
        bus.i_iss_rs2_addr = '0;
        bus.i_alu_valid    = 1'b0;
        bus.i_alu_rd_addr  = '0;
        bus.i_alu_data     = '0;
        bus.i_lsu_valid    = 1'b0;
        bus.i_lsu_rd_addr  = '0;
        bus.i_lsu_data     = '0;
    endtask

    task automatic issue(logic v, logic [4:0] rd, logic [4:0] rs1,
                         logic [4:0] rs2);
        bus.i_iss_valid    = v;
        bus.i_iss_rd_addr  = rd;
        bus.i_iss_rs1_addr = rs1;
        bus.i_iss_rs2_addr = rs2;
    endtask

    // Called at a falling edge with inputs applied; checks, advances the
    // model past the next rising edge and returns at the following fall.
    task automatic step();
        bit lp, ea, el, es;
        #1;
        lp = (streak >= STARVE_MAX);
        ea = bus.i_alu_valid && (!lp || !bus.i_lsu_valid);
        el = bus.i_lsu_valid && (lp || !bus.i_alu_valid);
        es = SB && bus.i_iss_valid &&
             (m_busy[bus.i_iss_rs1_addr] || m_busy[bus.i_iss_rs2_addr] ||
              m_busy[bus.i_iss_rd_addr]);
        obs_alu   = bus.o_alu_ready;
        obs_lsu   = bus.o_lsu_ready;
        obs_stall = bus.o_iss_stall;
        chk("alu_ready", 32'(obs_alu), 32'(ea));
        chk("lsu_ready", 32'(obs_lsu), 32'(el));
        chk("iss_stall", 32'(obs_stall), 32'(es));
        chk("rd_wren", 32'(bus.o_rd_wren), 32'(m_wren));
        chk("rd_addr", 32'(bus.o_rd_addr), 32'(m_addr));
        chk("rd_data", bus.o_rd_data, m_data);
        if (m_wren)
            m_busy[m_addr] = 1'b0;
        if (bus.i_iss_valid && !es && bus.i_iss_rd_addr != 0)
            m_busy[bus.i_iss_rd_addr] = 1'b1;
        streak = (bus.i_lsu_valid && !el) ? streak + 1 : 0;
        if (ea && bus.i_alu_rd_addr != 0) begin
            m_wren = 1'b1;
            m_addr = bus.i_alu_rd_addr;
            m_data = bus.i_alu_data;
        end else if (el && bus.i_lsu_rd_addr != 0) begin
            m_wren = 1'b1;
            m_addr = bus.i_lsu_rd_addr;
            m_data = bus.i_lsu_data;
        end else begin
            m_wren = 1'b0;
        end
        g_alu = ea;
        g_lsu = el;
        @(negedge clk);
    endtask

    bit exp_lsu_seq [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        idle();
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst_wren", 32'(bus.o_rd_wren), 32'd0);
        chk("rst_addr", 32'(bus.o_rd_addr), 32'd0);
        chk("rst_data", bus.o_rd_data, 32'd0);
        chk("rst_stall", 32'(bus.o_iss_stall), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Single ALU write.
        bus.i_alu_valid   = 1'b1;
        bus.i_alu_rd_addr = 5'd5;
        bus.i_alu_data    = 32'hDEADBEEF;
        step();
        chk("alu5_wren", 32'(bus.o_rd_wren), 32'd1);
        chk("alu5_addr", 32'(bus.o_rd_addr), 32'd5);
        chk("alu5_data", bus.o_rd_data, 32'hDEADBEEF);
        idle();
        step();
        chk("alu5_wren_off", 32'(bus.o_rd_wren), 32'd0);

        // Starvation: both request every cycle.
        step();
        bus.i_alu_valid   = 1'b1;
        bus.i_alu_rd_addr = 5'd1;
        bus.i_lsu_valid   = 1'b1;
        bus.i_lsu_rd_addr = 5'd2;
        for (int i = 0; i < 5; i++) begin
            bus.i_alu_data = 32'h1000 + 32'(i);
            step();
            chk("starve_lsu_rdy", 32'(obs_lsu), 32'(exp_lsu_seq[i]));
            chk("starve_alu_rdy", 32'(obs_alu), 32'(!exp_lsu_seq[i]));
            if (g_lsu)
                bus.i_lsu_data = bus.i_lsu_data + 32'd1;
        end
        idle();
        step();

        // x0 write from the LSU, and an x0 issue that must not set busy.
        bus.i_lsu_valid   = 1'b1;
        bus.i_lsu_rd_addr = 5'd0;
        bus.i_lsu_data    = 32'h1234;
        issue(1'b1, 5'd0, 5'd0, 5'd0);
        step();
        chk("x0_lsu_rdy", 32'(obs_lsu), 32'd1);
        chk("x0_wren", 32'(bus.o_rd_wren), 32'd0);
        idle();
        issue(1'b1, 5'd3, 5'd0, 5'd0);
        step();
        chk("x0_no_busy", 32'(obs_stall), 32'd0);
        idle();
        step();

        // RAW: rd=7 in flight, consumer reads rs1=7.
        issue(1'b1, 5'd7, 5'd0, 5'd0);
        step();
        issue(1'b1, 5'd8, 5'd7, 5'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("raw_stall", 32'(obs_stall), 32'(SB));
        end
        bus.i_alu_valid   = 1'b1;
        bus.i_alu_rd_addr = 5'd7;
        bus.i_alu_data    = 32'h7777_0001;
        step();
        chk("raw_stall_grant", 32'(obs_stall), 32'(SB));
        bus.i_alu_valid = 1'b0;
        step();
        chk("raw_stall_wb", 32'(obs_stall), 32'(SB));
        step();
        chk("raw_release", 32'(obs_stall), 32'd0);
        idle();
        step();

        // WAW: rd=7 issued twice.
        issue(1'b1, 5'd7, 5'd0, 5'd0);
        step();
        step();
        chk("waw_stall", 32'(obs_stall), 32'(SB));
        bus.i_lsu_valid   = 1'b1;
        bus.i_lsu_rd_addr = 5'd7;
        bus.i_lsu_data    = 32'h7777_0002;
        step();
        chk("waw_stall_grant", 32'(obs_stall), 32'(SB));
        bus.i_lsu_valid = 1'b0;
        step();
        chk("waw_stall_wb", 32'(obs_stall), 32'(SB));
        step();
        chk("waw_release", 32'(obs_stall), 32'd0);
        idle();
        step();

        // Reset mid-stream with a write pending and a busy register.
        issue(1'b1, 5'd9, 5'd0, 5'd0);
        bus.i_alu_valid   = 1'b1;
        bus.i_alu_rd_addr = 5'd4;
        bus.i_alu_data    = 32'hA5A5_0004;
        bus.i_lsu_valid   = 1'b1;
        bus.i_lsu_rd_addr = 5'd6;
        bus.i_lsu_data    = 32'h5A5A_0006;
        step();
        issue(1'b1, 5'd10, 5'd9, 5'd0);
        rst = 1'b1;
        #1;
        chk("mid_rst_wren", 32'(bus.o_rd_wren), 32'd0);
        chk("mid_rst_addr", 32'(bus.o_rd_addr), 32'd0);
        chk("mid_rst_data", bus.o_rd_data, 32'd0);
        chk("mid_rst_stall", 32'(bus.o_iss_stall), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        bus.i_alu_data = 32'hA5A5_0005;
        step();
        chk("post_rst_alu", 32'(obs_alu), 32'd1);
        chk("post_rst_lsu", 32'(obs_lsu), 32'd0);

        // Random traffic; a refused requester holds its request.
        for (int i = 0; i < 400; i++) begin
            if (!bus.i_alu_valid || g_alu) begin
                bus.i_alu_valid   = ($urandom_range(0, 99) < 60);
                bus.i_alu_rd_addr = 5'($urandom_range(0, 7));
                bus.i_alu_data    = $urandom;
            end
            if (!bus.i_lsu_valid || g_lsu) begin
                bus.i_lsu_valid   = ($urandom_range(0, 99) < 45);
                bus.i_lsu_rd_addr = 5'($urandom_range(0, 7));
                bus.i_lsu_data    = $urandom;
            end
            issue(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
